// File: rtl/gpio_in_pkg.sv
// gpio_in_pkg: register addresses and default geometry shared by the GPIO
// input port and the DE10-Nano board top.
package gpio_in_pkg;

   // Register select values for the addr port
   typedef enum logic [1:0] {
      GPIO_ADDR_LEVEL = 2'd0,
      GPIO_ADDR_RISE  = 2'd1,
      GPIO_ADDR_FALL  = 2'd2,
      GPIO_ADDR_MASK  = 2'd3
   } gpio_addr_e;

   // Board geometry: bit0-1 are KEY[1:0], bit2-5 are SW[3:0]
   localparam int GPIO_IN_WIDTH = 6;

   // KEYs are active-low on the board, so they are flipped to read 1 when pressed
   localparam logic [GPIO_IN_WIDTH-1:0] GPIO_IN_INVERT_MASK = 6'b000011;

   // Default debounce window (legal range 2..255) and counter width
   localparam int GPIO_IN_DEBOUNCE_CYCLES = 16;
   localparam int GPIO_IN_CNT_W           = 8;

   // Width of the CPU-facing read bus
   localparam int GPIO_RD_W = 32;

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one input bit -- two-flop synchroniser, debounce counter and
// accepted (stable) level. Emits a one-cycle event when a new level is accepted.
module gpio_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic din_i,
   output logic stable_o,
   output logic event_o,
   output logic level_o
);

   // Count value reached on the last cycle of the required stable run
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             evt;

   // Bring the asynchronous pin into the clock domain through two flops
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= din_i;
         s2_q <= s1_q;
      end
   end

   // Accept a new level only after it has differed from the stable one for
   // a full window; any return to the stable level restarts the count
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      evt      = 1'b0;
      if (s2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == TERMINAL) begin
         stable_d = s2_q;
         cnt_d    = '0;
         evt      = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Debounce state; reset discards any partial count
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;
   assign event_o  = evt;
   assign level_o  = s2_q;

endmodule

// File: rtl/gpio_input_port.sv
// gpio_input_port: conditioned KEY/SW inputs for the CPU. Each bit is
// polarity-normalised, synchronised and debounced; accepted edges are latched
// into read-to-clear pending registers behind a small read port.
// Optional feature macro: GPIO_IN_IRQ_EN -- when defined, adds the writable
// irq_mask register (addr 3) and a registered level interrupt; when undefined,
// irq is tied low, addr 3 reads 0 and writes are dropped.
module gpio_input_port
   import gpio_in_pkg::*;
#(
   parameter int               WIDTH           = GPIO_IN_WIDTH,
   parameter logic [WIDTH-1:0] INVERT_MASK     = WIDTH'(GPIO_IN_INVERT_MASK),
   parameter int               DEBOUNCE_CYCLES = GPIO_IN_DEBOUNCE_CYCLES,
   parameter int               CNT_W           = GPIO_IN_CNT_W
) (
   input  logic                 clock_in,
   input  logic                 reset_n_in,
   input  logic [WIDTH-1:0]     raw_in,
   input  logic                 rd_en,
   input  logic                 wr_en,
   input  logic [1:0]           addr,
   input  logic [GPIO_RD_W-1:0] wr_data,
   output logic [GPIO_RD_W-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 irq
);

   logic [WIDTH-1:0]     xIn;
   logic [WIDTH-1:0]     stableVec;
   logic [WIDTH-1:0]     eventVec;
   logic [WIDTH-1:0]     levelVec;
   logic [WIDTH-1:0]     riseEv;
   logic [WIDTH-1:0]     fallEv;
   logic [WIDTH-1:0]     clrRise;
   logic [WIDTH-1:0]     clrFall;
   logic [WIDTH-1:0]     rdSel;
   logic [WIDTH-1:0]     maskVal;
   logic [WIDTH-1:0]     risePend_q;
   logic [WIDTH-1:0]     risePend_d;
   logic [WIDTH-1:0]     fallPend_q;
   logic [WIDTH-1:0]     fallPend_d;
   logic [GPIO_RD_W-1:0] rdData_q;
   logic [GPIO_RD_W-1:0] rdData_d;
   logic                 rdValid_q;
   logic                 unusedWrBus;

   // Flip active-low pins so every bit reads 1 when asserted; the reset
   // value 0 of the stable level then matches idle keys
   assign xIn = raw_in ^ INVERT_MASK;

   // Only wr_data[WIDTH-1:0] is ever stored; the rest is intentionally ignored
   assign unusedWrBus = ^{wr_en, wr_data};

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_debounce (
         .clk_i   (clock_in),
         .rst_ni  (reset_n_in),
         .din_i   (xIn[i]),
         .stable_o(stableVec[i]),
         .event_o (eventVec[i]),
         .level_o (levelVec[i])
      );
   end

   // On an accept cycle the synchronised level is the new stable level,
   // so it tells us the direction of the edge
   assign riseEv = eventVec & levelVec;
   assign fallEv = eventVec & ~levelVec;

`ifdef GPIO_IN_IRQ_EN
   logic [WIDTH-1:0] irqMask_q;
   logic [WIDTH-1:0] irqMask_d;
   logic             irq_q;
   logic             irq_d;

   // Mask register is the only writable location; interrupt is any pending
   // edge that is unmasked, sampled from the registered pending bits
   always_comb begin
      irqMask_d = irqMask_q;
      if (wr_en && (addr == GPIO_ADDR_MASK)) begin
         irqMask_d = wr_data[WIDTH-1:0];
      end
      irq_d = |((risePend_q | fallPend_q) & irqMask_q);
   end

   // Mask and interrupt state
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         irqMask_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         irqMask_q <= irqMask_d;
         irq_q     <= irq_d;
      end
   end

   assign maskVal = irqMask_q;
   assign irq     = irq_q;
`else
   assign maskVal = '0;
   assign irq     = 1'b0;
`endif

   // Read decode: select the register, and for the pending registers clear
   // exactly the bits being returned so nothing captured later is lost
   always_comb begin
      rdSel    = '0;
      clrRise  = '0;
      clrFall  = '0;
      rdData_d = rdData_q;
      if (rd_en) begin
         case (addr)
            GPIO_ADDR_LEVEL: rdSel = stableVec;
            GPIO_ADDR_RISE: begin
               rdSel   = risePend_q;
               clrRise = risePend_q;
            end
            GPIO_ADDR_FALL: begin
               rdSel   = fallPend_q;
               clrFall = fallPend_q;
            end
            default: rdSel = maskVal;
         endcase
         rdData_d = GPIO_RD_W'(rdSel);
      end
   end

   // Pending edge update; a new edge in the same cycle as a clear survives
   always_comb begin
      risePend_d = (risePend_q & ~clrRise) | riseEv;
      fallPend_d = (fallPend_q & ~clrFall) | fallEv;
   end

   // Pending registers and the registered read port
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         risePend_q <= '0;
         fallPend_q <= '0;
         rdData_q   <= '0;
         rdValid_q  <= 1'b0;
      end else begin
         risePend_q <= risePend_d;
         fallPend_q <= fallPend_d;
         rdData_q   <= rdData_d;
         rdValid_q  <= rd_en;
      end
   end

   assign rd_data  = rdData_q;
   assign rd_valid = rdValid_q;

endmodule
